// File: rtl/brick_level_seq.sv
// Game-level sequencer: level progression, lives, game over and the LFSR random-board fill.
// Optional build macro BRICK_LVL_SKIP_EN adds a skipLevel input that wins the level from PLAY.
module brick_level_seq #(
  parameter int unsigned LIVES_INIT = 3,
  parameter int unsigned WIN_FRAMES = 60,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned GEN_CELLS  = 255,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startGame,
  input  logic       frameTick,
  input  logic       noBricks,
  input  logic       ballLost,
`ifdef BRICK_LVL_SKIP_EN
  input  logic       skipLevel,
`endif
  output logic [1:0] lvl,
  output logic       random,
  output logic [7:0] randomIndex,
  output logic [7:0] randomColor,
  output logic       playEnable,
  output logic [1:0] lives,
  output logic       levelDone,
  output logic       gameOver
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PLAY = 3'd1;
  localparam logic [2:0] S_WIN  = 3'd2;
  localparam logic [2:0] S_GEN  = 3'd3;
  localparam logic [2:0] S_OVER = 3'd4;

  localparam int unsigned SW = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);
  localparam int unsigned FW = (WIN_FRAMES < 2) ? 1 : $clog2(WIN_FRAMES + 1);

  logic [2:0]    state;
  logic [7:0]    lfsr;
  logic [SW-1:0] settle_cnt;
  logic [FW-1:0] frame_cnt;
  logic [8:0]    cell_cnt;
  logic          any_brick;

  logic [7:0]    lfsr_next;
  logic [7:0]    cell_raw;
  logic [7:0]    cell_color;
  logic          last_cell;
  logic          settled;
  logic          win_req;

  function automatic logic [7:0] color_map(input logic [2:0] sel);
    logic [7:0] c;
    case (sel)
      3'd3:    c = 8'h6D;
      3'd4:    c = 8'h1C;
      3'd5:    c = 8'hFC;
      3'd6:    c = 8'hE0;
      3'd7:    c = 8'h1F;
      default: c = 8'hFF;
    endcase
    return c;
  endfunction

  always_comb begin
    lfsr_next  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    cell_raw   = color_map(lfsr[2:0]);
    last_cell  = (cell_cnt == 9'(GEN_CELLS - 1));
    // An all-empty board would be won instantly, so the last cell becomes a brick if needed.
    cell_color = (last_cell && !any_brick && (cell_raw == 8'hFF)) ? 8'h6D : cell_raw;
    settled    = (settle_cnt == '0);
    win_req    = noBricks && settled;
`ifdef BRICK_LVL_SKIP_EN
    win_req    = win_req || skipLevel;
`endif
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= S_IDLE;
      lvl         <= '0;
      random      <= 1'b0;
      randomIndex <= '0;
      randomColor <= '1;
      playEnable  <= 1'b0;
      lives       <= '0;
      levelDone   <= 1'b0;
      gameOver    <= 1'b0;
      lfsr        <= LFSR_SEED;
      settle_cnt  <= '0;
      frame_cnt   <= '0;
      cell_cnt    <= '0;
      any_brick   <= 1'b0;
    end else begin
      levelDone <= 1'b0;
      case (state)
        S_IDLE, S_OVER: begin
          if (startGame) begin
            lvl        <= 2'd1;
            lives      <= 2'(LIVES_INIT);
            gameOver   <= 1'b0;
            state      <= S_PLAY;
            playEnable <= 1'b1;
            settle_cnt <= SW'(SETTLE_CYC);
          end
        end

        S_PLAY: begin
          if (!settled) settle_cnt <= settle_cnt - 1'b1;
          // A win in the same cycle as a ball loss takes priority; no life is lost.
          if (win_req) begin
            state      <= S_WIN;
            playEnable <= 1'b0;
            levelDone  <= 1'b1;
            frame_cnt  <= '0;
          end else if (ballLost) begin
            if (lives > 2'd1) begin
              lives <= lives - 2'd1;
            end else begin
              lives      <= '0;
              state      <= S_OVER;
              playEnable <= 1'b0;
              gameOver   <= 1'b1;
            end
          end
        end

        S_WIN: begin
          if (frame_cnt == FW'(WIN_FRAMES)) begin
            frame_cnt <= '0;
            if (lvl == 2'd1) begin
              lvl        <= 2'd2;
              state      <= S_PLAY;
              playEnable <= 1'b1;
              settle_cnt <= SW'(SETTLE_CYC);
            end else begin
              lvl       <= 2'd3;
              state     <= S_GEN;
              random    <= 1'b1;
              cell_cnt  <= '0;
              any_brick <= 1'b0;
            end
          end else if (frameTick) begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end

        S_GEN: begin
          randomIndex <= cell_cnt[7:0];
          randomColor <= cell_color;
          lfsr        <= lfsr_next;
          cell_cnt    <= cell_cnt + 1'b1;
          if (cell_color != 8'hFF) any_brick <= 1'b1;
          if (last_cell) begin
            random     <= 1'b0;
            state      <= S_PLAY;
            playEnable <= 1'b1;
            settle_cnt <= SW'(SETTLE_CYC);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_brick_level_seq.sv
// Self-checking bench for brick_level_seq: vector table, directed corner sequences and
// randomized play checked against a cycle-level behavioural model of the game rules.
module tb_brick_level_seq;

  localparam int unsigned LIVES_INIT = 3;
  localparam int unsigned WIN_FRAMES = 60;
  localparam int unsigned SETTLE_CYC = 4;
  localparam int unsigned GEN_CELLS  = 255;
  localparam logic [7:0]  LFSR_SEED  = 8'hA5;

  localparam int P_IDLE = 0;
  localparam int P_PLAY = 1;
  localparam int P_WIN  = 2;
  localparam int P_GEN  = 3;
  localparam int P_OVER = 4;

  logic       clk = 1'b0;
  logic       resetN;
  logic       startGame, frameTick, noBricks, ballLost;
`ifdef BRICK_LVL_SKIP_EN
  logic       skipLevel;
`endif
  logic [1:0] lvl, lives;
  logic       random, playEnable, levelDone, gameOver;
  logic [7:0] randomIndex, randomColor;

  brick_level_seq #(
    .LIVES_INIT(LIVES_INIT),
    .WIN_FRAMES(WIN_FRAMES),
    .SETTLE_CYC(SETTLE_CYC),
    .GEN_CELLS (GEN_CELLS),
    .LFSR_SEED (LFSR_SEED)
  ) dut (
    .clk        (clk),
    .resetN     (resetN),
    .startGame  (startGame),
    .frameTick  (frameTick),
    .noBricks   (noBricks),
    .ballLost   (ballLost),
`ifdef BRICK_LVL_SKIP_EN
    .skipLevel  (skipLevel),
`endif
    .lvl        (lvl),
    .random     (random),
    .randomIndex(randomIndex),
    .randomColor(randomColor),
    .playEnable (playEnable),
    .lives      (lives),
    .levelDone  (levelDone),
    .gameOver   (gameOver)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  int          m_ph;
  int unsigned m_age, m_ticks, m_k;
  logic [1:0]  m_lvl, m_lives;
  logic        m_rand, m_pe, m_ld, m_go;
  logic [7:0]  m_idx, m_col, m_lfsr;
  logic [7:0]  m_board [GEN_CELLS];
  bit          m_forced = 1'b0;

  typedef struct {
    bit s, t, n, l;
    logic [1:0] lvl, lives;
    bit pe, ld, go;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], ^(v & 8'hB8)};
  endfunction

  function automatic logic [7:0] cmap(input logic [7:0] v);
    case (v[2:0])
      3'd3:    return 8'h6D;
      3'd4:    return 8'h1C;
      3'd5:    return 8'hFC;
      3'd6:    return 8'hE0;
      3'd7:    return 8'h1F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic void build_board();
    int bricks = 0;
    for (int unsigned i = 0; i < GEN_CELLS; i++) begin
      logic [7:0] v;
      v = m_forced ? 8'h02 : m_lfsr;
      m_board[i] = cmap(v);
      if (m_board[i] != 8'hFF) bricks++;
      if (!m_forced) m_lfsr = lfsr_step(m_lfsr);
    end
    if (bricks == 0) m_board[GEN_CELLS-1] = 8'h6D;
  endfunction

  function automatic void model_reset();
    m_ph = P_IDLE; m_age = 0; m_ticks = 0; m_k = 0;
    m_lvl = 0; m_lives = 0; m_rand = 0; m_pe = 0; m_ld = 0; m_go = 0;
    m_idx = 8'h00; m_col = 8'hFF; m_lfsr = LFSR_SEED;
  endfunction

  function automatic void enter_play();
    m_ph = P_PLAY; m_pe = 1; m_age = 0;
  endfunction

  function automatic void model_edge(input bit s, t, n, l, k);
    m_ld = 0;
    case (m_ph)
      P_IDLE, P_OVER: if (s) begin
        m_lvl = 2'd1; m_lives = 2'(LIVES_INIT); m_go = 0; enter_play();
      end
      P_PLAY: begin
        if (k || (n && m_age >= SETTLE_CYC)) begin
          m_ph = P_WIN; m_pe = 0; m_ld = 1; m_ticks = 0;
        end else if (l) begin
          if (m_lives > 2'd1) m_lives = m_lives - 2'd1;
          else begin m_lives = 0; m_ph = P_OVER; m_pe = 0; m_go = 1; end
        end
        m_age++;
      end
      P_WIN: begin
        if (m_ticks == WIN_FRAMES) begin
          if (m_lvl == 2'd1) begin m_lvl = 2'd2; enter_play(); end
          else begin m_lvl = 2'd3; m_ph = P_GEN; m_rand = 1; m_k = 0; build_board(); end
        end else if (t) m_ticks++;
      end
      P_GEN: begin
        m_idx = 8'(m_k); m_col = m_board[m_k]; m_k++;
        if (m_k == GEN_CELLS) begin m_rand = 0; enter_play(); end
      end
      default: ;
    endcase
  endfunction

  task automatic check_all();
    chk("lvl", {6'd0, lvl}, {6'd0, m_lvl});
    chk("random", {7'd0, random}, {7'd0, m_rand});
    chk("randomIndex", randomIndex, m_idx);
    chk("randomColor", randomColor, m_col);
    chk("playEnable", {7'd0, playEnable}, {7'd0, m_pe});
    chk("lives", {6'd0, lives}, {6'd0, m_lives});
    chk("levelDone", {7'd0, levelDone}, {7'd0, m_ld});
    chk("gameOver", {7'd0, gameOver}, {7'd0, m_go});
  endtask

  task automatic step(input bit s, t, n, l, k);
    startGame = s; frameTick = t; noBricks = n; ballLost = l;
`ifdef BRICK_LVL_SKIP_EN
    skipLevel = k;
`endif
    @(posedge clk);
    model_edge(s, t, n, l, k);
    #1;
    check_all();
  endtask

  // From the first PLAY cycle: wait out the settle window, win, then sit out the WIN frames.
  task automatic clear_level();
    repeat (SETTLE_CYC) step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    repeat (WIN_FRAMES) step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
  endtask

  task automatic pulse_reset();
    resetN = 1'b0;
    #2;
    model_reset();
    check_all();
    chk("rst_random", {7'd0, random}, 8'h00);
    chk("rst_lvl", {6'd0, lvl}, 8'h00);
    resetN = 1'b1;
  endtask

  initial begin
    int rand_hi;
    tbl[0] = '{1, 0, 0, 0, 2'd1, 2'd3, 1, 0, 0};
    tbl[1] = '{0, 0, 1, 0, 2'd1, 2'd3, 1, 0, 0};
    tbl[2] = '{0, 0, 1, 0, 2'd1, 2'd3, 1, 0, 0};
    tbl[3] = '{0, 0, 1, 0, 2'd1, 2'd3, 1, 0, 0};
    tbl[4] = '{0, 0, 1, 0, 2'd1, 2'd3, 1, 0, 0};
    tbl[5] = '{0, 0, 1, 0, 2'd1, 2'd3, 0, 1, 0};
    tbl[6] = '{1, 0, 1, 0, 2'd1, 2'd3, 0, 0, 0};
    tbl[7] = '{0, 1, 0, 0, 2'd1, 2'd3, 0, 0, 0};

    resetN = 1'b0; startGame = 0; frameTick = 0; noBricks = 0; ballLost = 0;
`ifdef BRICK_LVL_SKIP_EN
    skipLevel = 0;
`endif
    model_reset();
    #12;
    check_all();
    chk("rst_color", randomColor, 8'hFF);
    chk("rst_lives", {6'd0, lives}, 8'h00);
    #1 resetN = 1'b1;

    // start, settle window, levelDone width, startGame ignored in WIN
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].s, tbl[i].t, tbl[i].n, tbl[i].l, 0);
      chk($sformatf("tbl%0d_lvl", i), {6'd0, lvl}, {6'd0, tbl[i].lvl});
      chk($sformatf("tbl%0d_lives", i), {6'd0, lives}, {6'd0, tbl[i].lives});
      chk($sformatf("tbl%0d_pe", i), {7'd0, playEnable}, {7'd0, tbl[i].pe});
      chk($sformatf("tbl%0d_ld", i), {7'd0, levelDone}, {7'd0, tbl[i].ld});
      chk($sformatf("tbl%0d_go", i), {7'd0, gameOver}, {7'd0, tbl[i].go});
    end
    repeat (WIN_FRAMES - 1) step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("lvl2_entry", {6'd0, lvl}, 8'd2);
    chk("lvl2_pe", {7'd0, playEnable}, 8'd1);

    // level 2 -> random board generation
    clear_level();
    chk("gen_lvl", {6'd0, lvl}, 8'd3);
    chk("gen_random_on", {7'd0, random}, 8'd1);
    rand_hi = 1;
    for (int i = 0; i < int'(GEN_CELLS); i++) begin
      step(0, 0, 0, 0, 0);
      if (i == 0) chk("gen_first_color", randomColor, cmap(LFSR_SEED));
      chk("gen_idx_seq", randomIndex, 8'(i));
      if (random) rand_hi++;
    end
    chk("gen_random_cycles", 8'(rand_hi), 8'(GEN_CELLS));
    chk("gen_back_to_play", {7'd0, playEnable}, 8'd1);

    // ball loss and win together after settle, then reset during generation
    repeat (SETTLE_CYC) step(0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    chk("tie_lives", {6'd0, lives}, 8'd3);
    chk("tie_leveldone", {7'd0, levelDone}, 8'd1);
    repeat (WIN_FRAMES) step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    repeat (40) step(0, 0, 0, 0, 0);
    pulse_reset();
    repeat (3) step(0, 0, 0, 0, 0);

    // lives run out, restart from OVER
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("over_lives", {6'd0, lives}, 8'd0);
    chk("over_flag", {7'd0, gameOver}, 8'd1);
    chk("over_pe", {7'd0, playEnable}, 8'd0);
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    chk("restart_lvl", {6'd0, lvl}, 8'd1);
    chk("restart_lives", {6'd0, lives}, 8'd3);
    chk("restart_go", {7'd0, gameOver}, 8'd0);

    // randomized play against the model
    for (int i = 0; i < 4000; i++) begin
      bit rs, rt, rn, rl, rk;
      rs = ($urandom_range(0, 63) == 0);
      rt = $urandom_range(0, 1) == 1;
      rn = ($urandom_range(0, 5) == 0);
      rl = ($urandom_range(0, 23) == 0);
      rk = 0;
`ifdef BRICK_LVL_SKIP_EN
      rk = ($urandom_range(0, 99) == 0);
`endif
      step(rs, rt, rn, rl, rk);
    end

    // all-empty LFSR mapping: last cell must be forced to a brick
    step(0, 0, 0, 0, 0);
    pulse_reset();
    step(1, 0, 0, 0, 0);
    clear_level();
    force dut.lfsr = 8'h02;
    m_forced = 1'b1;
    clear_level();
    repeat (GEN_CELLS) step(0, 0, 0, 0, 0);
    chk("empty_last_idx", randomIndex, 8'd254);
    chk("empty_last_color", randomColor, 8'h6D);
    release dut.lfsr;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
